// File: rtl/layer1_weight_buffer.sv
// layer1_weight_buffer: captures the layer-1 loader's 25 packed kernel-tap words
// into a register file, then serves one channel's full 5x5 kernel per read.
// Latency: read result 1 cycle after request. No backpressure: reads are
// accepted every cycle; loader traffic after the 25th word is ignored.
// Ports: clk/rst_n (sync active-low); weights/wen loader input;
// reload restarts capture; rd_en/rd_ch read request;
// kern/rd_valid/rd_err registered read result; ready/fill_count capture status.
module layer1_weight_buffer #(
  parameter int DW   = 16,
  parameter int NCH  = 6,
  parameter int TAPS = 25
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*DW-1:0]    weights,
  input  logic                 wen,
  input  logic                 reload,
  input  logic                 rd_en,
  input  logic [2:0]           rd_ch,
  output logic [TAPS*DW-1:0]   kern,
  output logic                 rd_valid,
  output logic                 rd_err,
  output logic                 ready,
  output logic [4:0]           fill_count
);

  typedef enum logic {FILL, READY} state_t;

  localparam logic [4:0] LAST_SLOT = 5'(TAPS - 1);
  localparam logic [4:0] FULL_CNT  = 5'(TAPS);

  state_t state;

  logic [NCH*DW-1:0]  mem [TAPS];
  logic [TAPS*DW-1:0] kern_next;
  logic               ch_ok;
  logic               do_write;

  // A write only lands while filling and never on a reload edge.
  assign do_write = rst_n && !reload && wen && (state == FILL);

  // Register file has no reset; its contents are only exposed once ready.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[fill_count] <= weights;
    end
  end

  // Gather lane rd_ch of every slot; constant slices keep the mux simple.
  always_comb begin
    kern_next = '0;
    ch_ok     = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (rd_ch == 3'(c)) begin
        ch_ok = 1'b1;
        for (int k = 0; k < TAPS; k++) begin
          kern_next[k*DW +: DW] = mem[k][c*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FILL;
      fill_count <= '0;
      ready      <= 1'b0;
      rd_valid   <= 1'b0;
      rd_err     <= 1'b0;
      kern       <= '0;
    end else begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;

      // Capture progress; reload wins over any coincident write.
      if (reload) begin
        state      <= FILL;
        fill_count <= '0;
        ready      <= 1'b0;
      end else begin
        case (state)
          FILL: begin
            if (wen) begin
              fill_count <= fill_count + 5'd1;
              if (fill_count == LAST_SLOT) begin
                state <= READY;
                ready <= 1'b1;
              end
            end
          end
          READY: begin
            fill_count <= FULL_CNT;
            ready      <= 1'b1;
          end
          default: begin
            state      <= FILL;
            fill_count <= '0;
            ready      <= 1'b0;
          end
        endcase
      end

      // Read service uses the ready flag as it stood before this edge; a
      // reload on the same edge invalidates the contents, so it is rejected.
      if (rd_en) begin
        if (!reload && ready && ch_ok) begin
          kern     <= kern_next;
          rd_valid <= 1'b1;
        end else begin
          rd_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer1_weight_buffer.sv
// Bench for layer1_weight_buffer: directed scenarios plus a random phase,
// all compared every cycle against a queue-based model of the buffer.
module tb_layer1_weight_buffer;

  localparam int DW   = 16;
  localparam int NCH  = 6;
  localparam int TAPS = 25;

  logic                clk;
  logic                rst_n;
  logic [NCH*DW-1:0]   weights;
  logic                wen;
  logic                reload;
  logic                rd_en;
  logic [2:0]          rd_ch;
  logic [TAPS*DW-1:0]  kern;
  logic                rd_valid;
  logic                rd_err;
  logic                ready;
  logic [4:0]          fill_count;

  layer1_weight_buffer #(.DW(DW), .NCH(NCH), .TAPS(TAPS)) dut (
    .clk(clk), .rst_n(rst_n), .weights(weights), .wen(wen), .reload(reload),
    .rd_en(rd_en), .rd_ch(rd_ch), .kern(kern), .rd_valid(rd_valid),
    .rd_err(rd_err), .ready(ready), .fill_count(fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the stored words are simply a queue of what was accepted.
  logic [NCH*DW-1:0]  words[$];
  logic [TAPS*DW-1:0] m_kern;
  logic               m_valid;
  logic               m_err;

  function automatic logic [NCH*DW-1:0] pat(input int k, input bit inv);
    logic [NCH*DW-1:0] w;
    for (int c = 0; c < NCH; c++) w[c*DW +: DW] = 16'((c << 8) | k);
    return inv ? ~w : w;
  endfunction

  function automatic logic [NCH*DW-1:0] rnd_word();
    logic [NCH*DW-1:0] w;
    for (int c = 0; c < NCH; c++) w[c*DW +: DW] = 16'($urandom);
    return w;
  endfunction

  task automatic model_edge();
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (!rst_n) begin
      words.delete();
      m_kern = '0;
    end else begin
      if (rd_en) begin
        if (reload || words.size() != TAPS || rd_ch >= NCH) begin
          m_err = 1'b1;
        end else begin
          for (int k = 0; k < TAPS; k++) m_kern[k*DW +: DW] = words[k][rd_ch*DW +: DW];
          m_valid = 1'b1;
        end
      end
      if (reload) words.delete();
      else if (wen && words.size() < TAPS) words.push_back(weights);
    end
  endtask

  task automatic chk(input string tag, input logic [TAPS*DW-1:0] obs, input logic [TAPS*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("fill_count", 400'(fill_count), 400'(words.size()));
    chk("ready", 400'(ready), 400'(words.size() == TAPS));
    chk("rd_valid", 400'(rd_valid), 400'(m_valid));
    chk("rd_err", 400'(rd_err), 400'(m_err));
    chk("kern", kern, m_kern);
  endtask

  task automatic idle();
    wen = 1'b0; reload = 1'b0; rd_en = 1'b0; rd_ch = 3'd0;
  endtask

  task automatic do_read(input int ch);
    rd_en = 1'b1; rd_ch = 3'(ch);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  logic [NCH*DW-1:0] neg_word;

  initial begin
    rst_n = 1'b0; weights = '0;
    idle();
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Straight fill with 5 repeats of the last word past the end.
    for (int k = 0; k < TAPS + 5; k++) begin
      wen = 1'b1; weights = pat((k < TAPS) ? k : TAPS - 1, 1'b0);
      tick();
    end
    wen = 1'b0;
    do_read(3);
    chk("tap0_ch3", 400'(kern[0 +: DW]), 400'(16'h0300));
    chk("tap24_ch3", 400'(kern[24*DW +: DW]), 400'(16'h0318));

    // Gapped fill, with early reads that must be rejected.
    do_reload();
    for (int k = 0; k < TAPS; k++) begin
      wen = 1'b1; weights = pat(k, 1'b0);
      rd_en = (k % 7 == 3); rd_ch = 3'($urandom_range(0, 5));
      tick();
      wen = 1'b0; rd_en = 1'b0; weights = rnd_word();
      tick();
    end
    do_read(0);
    chk("tap24_ch0", 400'(kern[24*DW +: DW]), 400'(16'h0018));
    do_read(6);
    do_read(7);

    // Random words with a negative lane, then back-to-back reads of all lanes.
    do_reload();
    for (int k = 0; k < TAPS; k++) begin
      neg_word = rnd_word();
      neg_word[2*DW +: DW] = 16'hFF80;
      wen = 1'b1; weights = neg_word;
      tick();
    end
    wen = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      rd_en = 1'b1; rd_ch = 3'(c);
      tick();
      if (c == 2) chk("neg_tap7", 400'(kern[7*DW +: DW]), 400'(16'hFF80));
    end
    rd_en = 1'b0;

    // Reload coincident with a read and a write while ready.
    reload = 1'b1; rd_en = 1'b1; rd_ch = 3'd1; wen = 1'b1; weights = rnd_word();
    tick();
    idle();
    for (int k = 0; k < TAPS; k++) begin
      wen = 1'b1; weights = pat(k, 1'b1);
      tick();
    end
    wen = 1'b0;
    for (int c = 0; c < 8; c++) do_read(c);

    // Reset part-way through a fill, then refill.
    do_reload();
    for (int k = 0; k < 12; k++) begin
      wen = 1'b1; weights = pat(k, 1'b1);
      tick();
    end
    rst_n = 1'b0; rd_en = 1'b1;
    tick();
    rst_n = 1'b1; rd_en = 1'b0;
    for (int k = 0; k < TAPS; k++) begin
      wen = 1'b1; weights = pat(k, 1'b0);
      tick();
    end
    wen = 1'b0;
    for (int c = 0; c < NCH; c++) do_read(c);

    // Random phase.
    for (int i = 0; i < 600; i++) begin
      wen     = ($urandom_range(0, 3) != 0);
      weights = rnd_word();
      reload  = ($urandom_range(0, 79) == 0);
      rd_en   = ($urandom_range(0, 2) == 0);
      rd_ch   = 3'($urandom_range(0, 7));
      rst_n   = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer1_weight_buffer.md
Name: layer1_weight_buffer

Overview:
- Sits directly downstream of the layer-1 weight loader.
- Captures the 25 packed 96-bit kernel-tap words the loader streams out, qualified by its write-enable, into an on-chip register file.
- Serves the layer-1 convolution engine one full 5x5 kernel (25 taps) of a selected output channel per read request.
- Flags readiness once all taps are held, and ignores further loader traffic; the loader keeps wen high and repeats its last word indefinitely.

Parameters:
- DW, 16, width of one signed weight.
- NCH, 6, number of output channels packed per input word.
- TAPS, 25, kernel taps per channel (5x5, row-major).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- weights  input  NCH*DW (96)  signed packed tap word from loader; lane c = bits [16c+15:16c] = channel c.
- wen  input  1  loader write-enable; each cycle high delivers one tap word while filling.
- reload  input  1  single-cycle pulse; discard contents and recapture.
- rd_en  input  1  read request from conv engine.
- rd_ch  input  3  channel to read, 0..NCH-1.
- kern  output  TAPS*DW (400)  registered kernel; bits [16k+15:16k] = tap k of the read channel.
- rd_valid  output  1  one-cycle pulse; kern valid.
- rd_err  output  1  one-cycle pulse; request rejected.
- ready  output  1  all TAPS words captured.
- fill_count  output  5  words captured so far, 0..25.

Behaviour:
- Reset (rst_n=0 at clk edge): state FILL, fill_count=0, ready=0, rd_valid=0, rd_err=0, kern=0. Register-file contents are don't-care. Reset applies mid-fill or mid-read with no partial effects.
- State FILL:
  - Each edge with wen=1 writes weights into slot fill_count and increments fill_count.
  - The edge writing slot 24 moves the block to READY; fill_count=25 and ready=1 from the next cycle.
  - wen=0 cycles hold the count; gaps are allowed.
- State READY:
  - wen and weights are ignored; contents are frozen.
  - fill_count stays at 25.
- reload=1 at any edge in either state:
  - Go to FILL, fill_count=0, ready=0 next cycle.
  - reload has priority over a simultaneous wen write, which is dropped.
- Read channel, always sampled at the edge:
  - rd_en=1, ready=1, rd_ch<NCH: next cycle kern holds lane rd_ch of slots 0..24 (tap k = slot k lane rd_ch), rd_valid=1 for one cycle.
  - rd_en=1, rd_ch>=NCH (6,7): rd_err=1 for one cycle, rd_valid=0, kern holds its previous value.
  - rd_en=1, ready=0: rd_err=1 for one cycle, no data.
  - Same edge as a reload: rd_err=1, because the reload takes effect.
  - Back-to-back rd_en on consecutive cycles is allowed, giving one result per cycle. Latency is 1 cycle.
  - kern holds its last value when rd_en=0.
- No arithmetic on weights; signed bit patterns pass through unchanged.
- fill_count never exceeds 25 and never wraps.

Test Plan:
- Reset, then 25 cycles of wen=1 with word k lane c = 16'h(c)(k), i.e. (c<<8)|k, plus 5 extra repeated words -> ready rises the cycle after the 25th write, fill_count=25. Read rd_ch=3 -> rd_valid next cycle, kern tap k = 16'h03kk (k=0..24); extra words not stored.
- wen toggling 1/0 every cycle during fill -> ready only after 25 high cycles, about 50 cycles; read rd_ch=0 gives tap 24 = 16'h0018.
- Reads before ready, and rd_ch=6/7 after ready -> rd_err pulses, rd_valid=0, kern unchanged.
- Back-to-back reads rd_ch=0,1,...,5 on consecutive cycles -> six consecutive rd_valid pulses, each kern matching its channel; negative weights (lane=16'hFF80) pass through bit-exact.
- reload pulse in READY, coincident with rd_en and wen -> rd_err=1, ready=0, fill_count=0. Refill with a new pattern (lane = ~old) -> reads return the new values only.
- rst_n low at fill_count=12 -> fill_count=0, ready=0. A full 25-word refill then succeeds with correct contents.
